// File: rtl/data_mem_bus.sv
// -----------------------------------------------------------------------------
// data_mem_bus
//
// Byte-addressed data memory for the load/store stage of the RISC-V core.
// The memory is DEPTH words of 32 bits, held as four byte-wide lanes so that
// sub-word stores only touch the enabled lanes. Requests use a valid/ready
// handshake. Each request completes with a one-cycle rsp_valid pulse, which
// arrives WAIT_CYCLES+1 cycles after the accepting edge.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  extra stall cycles between accept and access (0..15)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  request present
//   req_ready  block can accept a request this cycle
//   memi       [4] unsigned load, [3:2] size (0 byte, 1 half, 2 word,
//              3 reserved), [1] write, [0] read
//   addr       byte address; bits above the word index are ignored
//   wdata      store data, right-aligned
//   rdata      load result, sign/zero extended to 32 bits
//   rsp_valid  one-cycle completion pulse
//   misalign   qualified by rsp_valid: the access was misaligned and suppressed
//
// Optional feature
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses are
//                          suppressed and flagged on misalign. When undefined,
//                          the low address bits are forced aligned and
//                          misalign is always 0.
// -----------------------------------------------------------------------------
module data_mem_bus #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  memi,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rsp_valid,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH);

    // The down-counter is loaded with WAIT_CYCLES-1 so that it spends exactly
    // WAIT_CYCLES cycles in S_WAIT before the access cycle.
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    // S_ACCESS is the single busy cycle that ends on the access edge; the RAM
    // read data needed there was registered on the previous edge.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic          misalign_q;
    logic [31:0]   rdata_q;
    logic [4:0]    memi_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;

    logic          accept;
    logic [1:0]    size_q;
    logic          is_read;
    logic          is_write;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] rd_idx;
    logic          misalign_d;
    logic          suppress_d;
    logic          wr_en;
    logic [3:0]    be_d;
    logic [31:0]   wr_data_d;
    logic [31:0]   rd_word;
    logic [7:0]    lane_byte;
    logic [15:0]   lane_half;
    logic [31:0]   load_d;
    logic [31:0]   rdata_d;

    // Address bits above the word index are deliberately ignored (wrap-around).
    logic          unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    assign accept    = req_valid && req_ready_q;
    assign size_q    = memi_q[3:2];
    assign is_write  = memi_q[1];
    assign is_read   = memi_q[0];
    assign idx_q     = addr_q[AW+1:2];

    // The lane RAMs read continuously. On an accepting edge the new address is
    // used directly so the word is already registered for a zero-wait access.
    assign rd_idx    = accept ? addr[AW+1:2] : addr_q[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_d = (is_read || is_write) &&
                        (((size_q == SZ_HALF) && addr_q[0]) ||
                         ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00)));
`else
    assign misalign_d = 1'b0;
`endif

    // Reserved size and trapped misaligned accesses neither write nor load.
    assign suppress_d = (size_q == SZ_RSVD) || misalign_d;
    assign wr_en      = (state_q == S_ACCESS) && is_write && !suppress_d;

    // Byte enables and lane-replicated store data. Half accesses look only at
    // addr[1] and word accesses at no low bits, which is what forces them
    // aligned when the trap is disabled.
    always_comb begin
        be_d      = 4'b0000;
        wr_data_d = wdata_q;
        unique case (size_q)
            SZ_BYTE: begin
                be_d      = 4'b0001 << addr_q[1:0];
                wr_data_d = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                be_d      = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data_d = {2{wdata_q[15:0]}};
            end
            SZ_WORD: begin
                be_d      = 4'b1111;
                wr_data_d = wdata_q;
            end
            default: begin
                be_d      = 4'b0000;
                wr_data_d = wdata_q;
            end
        endcase
    end

    // Four byte-wide lane RAMs with registered read. A write and a read of
    // the same word on one edge returns the old contents (read-first).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en && be_d[gi]) begin
                    mem[idx_q] <= wr_data_d[8*gi +: 8];
                end
                rd_q <= mem[rd_idx];
            end

            assign rd_word[8*gi +: 8] = rd_q;
        end
    endgenerate

    // Load alignment and extension. memi[4] selects zero extension; it has no
    // effect on word loads.
    always_comb begin
        lane_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
        lane_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        load_d    = 32'h0;
        unique case (size_q)
            SZ_BYTE: load_d = memi_q[4] ? {24'h0, lane_byte}
                                        : {{24{lane_byte[7]}}, lane_byte};
            SZ_HALF: load_d = memi_q[4] ? {16'h0, lane_half}
                                        : {{16{lane_half[15]}}, lane_half};
            SZ_WORD: load_d = rd_word;
            default: load_d = 32'h0;
        endcase
    end

    // rdata holds unless this response carries a load; suppressed accesses
    // (reserved size or trapped misalignment) return zero.
    always_comb begin
        rdata_d = rdata_q;
        if ((is_read || is_write) && suppress_d) begin
            rdata_d = 32'h0;
        end else if (is_read) begin
            rdata_d = load_d;
        end
    end

    // Control FSM with registered outputs. Accepts are allowed in S_IDLE and
    // S_RESP, so back-to-back requests overlap the response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            rdata_q     <= 32'h0;
            memi_q      <= 5'h0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            unique case (state_q)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        memi_q      <= memi;
                        addr_q      <= addr[AW+1:0];
                        wdata_q     <= wdata;
                        req_ready_q <= 1'b0;
                        cnt_q       <= WAIT_LOAD;
                        state_q     <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                    end else begin
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACCESS: begin
                    state_q     <= S_RESP;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    misalign_q  <= misalign_d;
                    rdata_q     <= rdata_d;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign misalign  = misalign_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_data_mem_bus.sv
// -----------------------------------------------------------------------------
// tb_data_mem_bus
//
// Directed bench for data_mem_bus. Two instances share the clock: u_fast with
// WAIT_CYCLES=0 and u_slow with WAIT_CYCLES=3, both DEPTH=256. Inputs are
// driven on the falling edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_data_mem_bus;

    logic        clk;
    logic        rst0, rv0, rr0, rsp0, mis0;
    logic [4:0]  memi0;
    logic [31:0] addr0, wd0, rd0;
    logic        rst3, rv3, rr3, rsp3, mis3;
    logic [4:0]  memi3;
    logic [31:0] addr3, wd3, rd3;

    int n_tests = 0;
    int n_fail  = 0;

    data_mem_bus #(.DEPTH(256), .WAIT_CYCLES(0)) u_fast (
        .clk(clk), .rst(rst0), .req_valid(rv0), .req_ready(rr0), .memi(memi0),
        .addr(addr0), .wdata(wd0), .rdata(rd0), .rsp_valid(rsp0), .misalign(mis0)
    );

    data_mem_bus #(.DEPTH(256), .WAIT_CYCLES(3)) u_slow (
        .clk(clk), .rst(rst3), .req_valid(rv3), .req_ready(rr3), .memi(memi3),
        .addr(addr3), .wdata(wd3), .rdata(rd3), .rsp_valid(rsp3), .misalign(mis3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    // Issue one request and wait for its response. lat counts rising edges
    // from the accepting edge to the start of the rsp_valid cycle. Inputs are
    // scrambled right after accept so a design that fails to latch shows up.
    task automatic txn(input bit slow, input logic [4:0] m, input logic [31:0] a,
                       input logic [31:0] d, output int lat,
                       output logic [31:0] rd, output logic mis);
        @(negedge clk);
        if (slow) begin rv3 = 1'b1; memi3 = m; addr3 = a; wd3 = d; end
        else      begin rv0 = 1'b1; memi0 = m; addr0 = a; wd0 = d; end
        @(posedge clk);
        @(negedge clk);
        if (slow) begin rv3 = 1'b0; memi3 = 5'h0A; addr3 = 32'hFFFF_FFFC; wd3 = 32'h5A5A_5A5A; end
        else      begin rv0 = 1'b0; memi0 = 5'h0A; addr0 = 32'hFFFF_FFFC; wd0 = 32'h5A5A_5A5A; end
        lat = 0;
        while (lat < 20 && !(slow ? rsp3 : rsp0)) begin
            @(negedge clk);
            lat++;
        end
        rd  = slow ? rd3 : rd0;
        mis = slow ? mis3 : mis0;
        $display("[TB] txn %s memi=%h addr=%h wdata=%h -> rdata=%h misalign=%b latency=%0d",
                 slow ? "slow" : "fast", m, a, d, rd, mis, lat);
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected %h", rd0, 32'h0); end
        n_tests++; if (rsp0 !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp0); end
        n_tests++; if (mis0 !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", mis0); end
        n_tests++; if (rr0 !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", rr0); end
        n_tests++; if (rr3 !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready_slow: got %b expected 1", rr3); end
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);
        n_tests++; if (rr0 !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 1", rr0); end
        n_tests++; if (rsp0 !== 1'b0) begin n_fail++; $display("FAIL post_reset_rsp: got %b expected 0", rsp0); end
    endtask

    task automatic test_word();
        int lat; logic [31:0] r; logic m;
        txn(1'b0, 5'h0A, 32'h10, 32'hDEAD_BEEF, lat, r, m);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL word_store_latency: got %0d expected 1", lat); end
        txn(1'b0, 5'h09, 32'h10, 32'h0, lat, r, m);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL word_load_latency: got %0d expected 1", lat); end
        n_tests++; if (r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_load_data: got %h expected %h", r, 32'hDEAD_BEEF); end
        @(negedge clk);
        n_tests++; if (rsp0 !== 1'b0) begin n_fail++; $display("FAIL rsp_single_cycle: got %b expected 0", rsp0); end
    endtask

    task automatic test_byte();
        int lat; logic [31:0] r; logic m;
        txn(1'b0, 5'h0A, 32'h10, 32'h0, lat, r, m);
        txn(1'b0, 5'h02, 32'h13, 32'h1234_5680, lat, r, m);
        txn(1'b0, 5'h01, 32'h13, 32'h0, lat, r, m);
        n_tests++; if (r !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL byte_signed: got %h expected %h", r, 32'hFFFF_FF80); end
        txn(1'b0, 5'h11, 32'h13, 32'h0, lat, r, m);
        n_tests++; if (r !== 32'h0000_0080) begin n_fail++; $display("FAIL byte_unsigned: got %h expected %h", r, 32'h0000_0080); end
        txn(1'b0, 5'h09, 32'h10, 32'h0, lat, r, m);
        n_tests++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL byte_word_view: got %h expected %h", r, 32'h8000_0000); end
    endtask

    task automatic test_half();
        int lat; logic [31:0] r; logic m;
        txn(1'b0, 5'h0A, 32'h20, 32'h1122_3344, lat, r, m);
        txn(1'b0, 5'h06, 32'h22, 32'h0000_A5A5, lat, r, m);
        txn(1'b0, 5'h05, 32'h22, 32'h0, lat, r, m);
        n_tests++; if (r !== 32'hFFFF_A5A5) begin n_fail++; $display("FAIL half_signed: got %h expected %h", r, 32'hFFFF_A5A5); end
        txn(1'b0, 5'h09, 32'h20, 32'h0, lat, r, m);
        n_tests++; if (r !== 32'hA5A5_3344) begin n_fail++; $display("FAIL half_word_view: got %h expected %h", r, 32'hA5A5_3344); end
        txn(1'b0, 5'h15, 32'h20, 32'h0, lat, r, m);
        n_tests++; if (r !== 32'h0000_3344) begin n_fail++; $display("FAIL half_unsigned_low: got %h expected %h", r, 32'h0000_3344); end
        txn(1'b0, 5'h01, 32'h21, 32'h0, lat, r, m);
        n_tests++; if (r !== 32'h0000_0033) begin n_fail++; $display("FAIL byte_lane1: got %h expected %h", r, 32'h0000_0033); end
        txn(1'b0, 5'h15, 32'h23, 32'h0, lat, r, m);
`ifdef DMEM_MISALIGN_TRAP_EN
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL half_misaligned_data: got %h expected %h", r, 32'h0); end
        n_tests++; if (m !== 1'b1) begin n_fail++; $display("FAIL half_misaligned_flag: got %b expected 1", m); end
`else
        n_tests++; if (r !== 32'h0000_A5A5) begin n_fail++; $display("FAIL half_forced_align: got %h expected %h", r, 32'h0000_A5A5); end
        n_tests++; if (m !== 1'b0) begin n_fail++; $display("FAIL half_forced_align_flag: got %b expected 0", m); end
`endif
    endtask

    task automatic test_rw_nop();
        int lat; logic [31:0] r; logic m;
        txn(1'b0, 5'h0A, 32'h30, 32'h0102_0304, lat, r, m);
        txn(1'b0, 5'h0B, 32'h30, 32'hCAFE_F00D, lat, r, m);
        n_tests++; if (r !== 32'h0102_0304) begin n_fail++; $display("FAIL read_before_write: got %h expected %h", r, 32'h0102_0304); end
        txn(1'b0, 5'h09, 32'h30, 32'h0, lat, r, m);
        n_tests++; if (r !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rw_committed: got %h expected %h", r, 32'hCAFE_F00D); end
        txn(1'b0, 5'h00, 32'h30, 32'h0, lat, r, m);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL nop_latency: got %0d expected 1", lat); end
        n_tests++; if (r !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL nop_hold: got %h expected %h", r, 32'hCAFE_F00D); end
        txn(1'b0, 5'h0A, 32'h34, 32'h0000_0055, lat, r, m);
        n_tests++; if (r !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL store_hold: got %h expected %h", r, 32'hCAFE_F00D); end
        txn(1'b0, 5'h0D, 32'h30, 32'h0, lat, r, m);
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL size3_data: got %h expected %h", r, 32'h0); end
        n_tests++; if (m !== 1'b0) begin n_fail++; $display("FAIL size3_misalign: got %b expected 0", m); end
    endtask

    task automatic test_back_to_back();
        logic exp_rsp;
        @(negedge clk);
        rv3 = 1'b1; memi3 = 5'h0A; addr3 = 32'h400; wd3 = 32'h0BAD_F00D;
        n_tests++; if (rr3 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle: got %b expected 1", rr3); end
        @(posedge clk);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            // Second request (aliased load of 0x000) is presented at once and
            // must only be taken in the first response cycle.
            if (k == 0) begin memi3 = 5'h09; addr3 = 32'h0; wd3 = 32'h0; end
            exp_rsp = (k == 4) || (k == 9);
            n_tests++; if (rsp3 !== exp_rsp) begin n_fail++; $display("FAIL b2b_rsp_%0d: got %b expected %b", k, rsp3, exp_rsp); end
            if (k inside {0, 1, 2, 5, 6, 7}) begin
                n_tests++; if (rr3 !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_wait_%0d: got %b expected 0", k, rr3); end
            end
            if (k == 4 || k == 9 || k == 10) begin
                n_tests++; if (rr3 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_resp_%0d: got %b expected 1", k, rr3); end
            end
            if (k == 4) $display("[TB] txn slow memi=0a addr=00000400 wdata=0badf00d -> rsp at cycle %0d", k);
            if (k == 9) begin
                $display("[TB] txn slow memi=09 addr=00000000 -> rdata=%h rsp at cycle %0d", rd3, k);
                n_tests++; if (rd3 !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL b2b_alias_data: got %h expected %h", rd3, 32'h0BAD_F00D); end
                rv3 = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] r; logic m; bit seen;
        txn(1'b1, 5'h0A, 32'h40, 32'h1111_1111, lat, r, m);
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL slow_latency: got %0d expected 4", lat); end
        @(negedge clk);
        rv3 = 1'b1; memi3 = 5'h0A; addr3 = 32'h40; wd3 = 32'h2222_2222;
        @(posedge clk);
        @(negedge clk);
        rv3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        n_tests++; if (rr3 !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", rr3); end
        n_tests++; if (rsp3 !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp: got %b expected 0", rsp3); end
        n_tests++; if (rd3 !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h expected %h", rd3, 32'h0); end
        @(negedge clk);
        rst3 = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp3) seen = 1'b1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rsp: got %b expected 0", seen); end
        txn(1'b1, 5'h09, 32'h40, 32'h0, lat, r, m);
        n_tests++; if (r !== 32'h1111_1111) begin n_fail++; $display("FAIL midrst_word_kept: got %h expected %h", r, 32'h1111_1111); end
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] r; logic m;
        txn(1'b0, 5'h0A, 32'h50, 32'h1234_5678, lat, r, m);
        txn(1'b0, 5'h0A, 32'h51, 32'hFFFF_FFFF, lat, r, m);
`ifdef DMEM_MISALIGN_TRAP_EN
        n_tests++; if (m !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b expected 1", m); end
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h expected %h", r, 32'h0); end
`else
        n_tests++; if (m !== 1'b0) begin n_fail++; $display("FAIL mis_flag: got %b expected 0", m); end
`endif
        @(negedge clk);
        n_tests++; if (mis0 !== 1'b0) begin n_fail++; $display("FAIL mis_clears: got %b expected 0", mis0); end
        txn(1'b0, 5'h09, 32'h50, 32'h0, lat, r, m);
`ifdef DMEM_MISALIGN_TRAP_EN
        n_tests++; if (r !== 32'h1234_5678) begin n_fail++; $display("FAIL mis_mem_unchanged: got %h expected %h", r, 32'h1234_5678); end
`else
        n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mis_forced_align: got %h expected %h", r, 32'hFFFF_FFFF); end
`endif
    endtask

    initial begin
        rst0 = 1'b1; rv0 = 1'b0; memi0 = 5'h0; addr0 = 32'h0; wd0 = 32'h0;
        rst3 = 1'b1; rv3 = 1'b0; memi3 = 5'h0; addr3 = 32'h0; wd3 = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_rw_nop();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
